// File: rtl/wiper_pkg.sv
// Shared types for the windscreen wiper motor controller.
package wiper_pkg;

  // Requested wiper speed after folding the unused code 3 onto fast.
  typedef enum logic [1:0] {
    SPD_OFF  = 2'd0,
    SPD_SLOW = 2'd1,
    SPD_FAST = 2'd2
  } speed_t;

  // Controller states.
  typedef enum logic [2:0] {
    ST_PARKED = 3'd0,
    ST_LEAVE  = 3'd1,
    ST_RETURN = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_FAULT  = 3'd4
  } wiper_state_t;

  // Map the raw 2-bit stalk input onto a speed; code 3 runs fast.
  function automatic speed_t decode_speed(input logic [1:0] req);
    speed_t s;
    case (req)
      2'd0:    s = SPD_OFF;
      2'd1:    s = SPD_SLOW;
      default: s = SPD_FAST;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wiper_motor_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous park sensor.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous input and re-register it to settle metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wiper_motor_ctrl.sv
// Wiper motor controller: sweeps the blade off park and back, with slow
// (paused), fast (continuous) and single manual sweeps, a per-leg timeout
// that latches a fault, and a wrapping count of completed sweeps.
module wiper_motor_ctrl #(
  parameter int SLOW_PAUSE    = 20,
  parameter int SWEEP_TIMEOUT = 64
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] speed_req,
  input  logic       wipe_once,
  input  logic       park_n,
  input  logic       fault_clr,
  output logic       motor_on,
  output logic       motor_fast,
  output logic [7:0] sweep_cnt,
  output logic       busy,
  output logic       fault
);

  import wiper_pkg::*;

  // One counter serves both the leg timeout and the slow-mode pause, so it
  // must hold the larger of the two limits without wrapping.
  localparam int CNT_MAX = (SWEEP_TIMEOUT > SLOW_PAUSE) ? SWEEP_TIMEOUT : SLOW_PAUSE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(SWEEP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(SLOW_PAUSE - 1);

  wiper_state_t     state;
  wiper_state_t     nxt_state;
  logic [CNT_W-1:0] phase_cnt;
  logic             park_s;
  logic             pending;
  logic             manual_req;
  logic             sweep_done;
  logic             enter_leave;
  speed_t           speed;

  sync_2ff u_park_sync (
    .clk   (clk_2),
    .reset (reset),
    .d     (park_n),
    .q     (park_s)
  );

  // Next-state selection from the current state, speed, manual request and park sensor.
  always_comb begin
    speed      = decode_speed(speed_req);
    // A pulse arriving this cycle counts as pending so it is never lost.
    manual_req = pending | wipe_once;
    nxt_state  = state;
    case (state)
      ST_PARKED: begin
        if (speed != SPD_OFF || manual_req) nxt_state = ST_LEAVE;
      end
      ST_LEAVE: begin
        if (park_s)                      nxt_state = ST_RETURN;
        else if (phase_cnt == TMO_LAST)  nxt_state = ST_FAULT;
      end
      ST_RETURN: begin
        if (!park_s) begin
          case (speed)
            SPD_FAST: nxt_state = ST_LEAVE;
            SPD_SLOW: nxt_state = ST_PAUSE;
            default:  nxt_state = manual_req ? ST_LEAVE : ST_PARKED;
          endcase
        end else if (phase_cnt == TMO_LAST) begin
          nxt_state = ST_FAULT;
        end
      end
      ST_PAUSE: begin
        if (speed == SPD_FAST)                      nxt_state = ST_LEAVE;
        else if (speed == SPD_OFF && !manual_req)   nxt_state = ST_PARKED;
        else if (phase_cnt == PAUSE_LAST)           nxt_state = ST_LEAVE;
      end
      ST_FAULT: begin
        if (fault_clr) nxt_state = ST_PARKED;
      end
      default: nxt_state = ST_PARKED;
    endcase
    sweep_done  = (state == ST_RETURN) && !park_s;
    enter_leave = (nxt_state == ST_LEAVE) && (state != ST_LEAVE);
  end

  // State, phase counter, pending flag, sweep count and registered outputs.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state      <= ST_PARKED;
      phase_cnt  <= '0;
      pending    <= 1'b0;
      sweep_cnt  <= 8'd0;
      motor_on   <= 1'b0;
      motor_fast <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= nxt_state;

      // Restart on every state change; only timed states advance it.
      if (nxt_state != state)
        phase_cnt <= '0;
      else if (state == ST_LEAVE || state == ST_RETURN || state == ST_PAUSE)
        phase_cnt <= phase_cnt + 1'b1;
      else
        phase_cnt <= '0;

      // Starting a sweep consumes the manual request; a fault ignores new ones.
      if (enter_leave)
        pending <= 1'b0;
      else if (wipe_once && state != ST_FAULT)
        pending <= 1'b1;

      if (sweep_done)
        sweep_cnt <= sweep_cnt + 8'd1;

      // The winding select only changes at the start of a sweep.
      if (enter_leave)
        motor_fast <= (speed == SPD_FAST);
      else if (nxt_state == ST_FAULT)
        motor_fast <= 1'b0;

      motor_on <= (nxt_state == ST_LEAVE) || (nxt_state == ST_RETURN);
      busy     <= (nxt_state != ST_PARKED);
      fault    <= (nxt_state == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_wiper_motor_ctrl.sv
// Self-checking bench for wiper_motor_ctrl with a blade/park-sensor model
// and a behavioural reference of the controller.
module tb_wiper_motor_ctrl;

  localparam int SP = 4;
  localparam int TO = 16;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] speed_req = 2'd0;
  logic       wipe_once = 1'b0;
  logic       park_n = 1'b0;
  logic       fault_clr = 1'b0;
  logic       motor_on;
  logic       motor_fast;
  logic [7:0] sweep_cnt;
  logic       busy;
  logic       fault;

  wiper_motor_ctrl #(.SLOW_PAUSE(SP), .SWEEP_TIMEOUT(TO)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .speed_req  (speed_req),
    .wipe_once  (wipe_once),
    .park_n     (park_n),
    .fault_clr  (fault_clr),
    .motor_on   (motor_on),
    .motor_fast (motor_fast),
    .sweep_cnt  (sweep_cnt),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk_2 = ~clk_2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: blade running / direction / pausing / faulted, with
  // leg and pause lengths measured as edges elapsed since the leg began.
  bit m_fault, m_run, m_out, m_pausing, m_manual, m_fast;
  int m_sweeps;
  int m_cyc, m_entry;
  bit s1, s2, m_ps;

  task automatic start_sweep();
    m_run = 1; m_out = 1; m_pausing = 0; m_manual = 0;
    m_entry = m_cyc;
    m_fast = (speed_req >= 2);
  endtask

  task automatic go_fault();
    m_run = 0; m_out = 0; m_pausing = 0; m_fault = 1; m_fast = 0;
  endtask

  task automatic model_step(input bit ps);
    bit man;
    if (!m_fault && wipe_once) m_manual = 1;
    man = m_manual;
    if (m_fault) begin
      if (fault_clr) m_fault = 0;
    end else if (m_run && m_out) begin
      if (ps) begin m_out = 0; m_entry = m_cyc; end
      else if (m_cyc - m_entry >= TO) go_fault();
    end else if (m_run) begin
      if (!ps) begin
        m_sweeps = (m_sweeps + 1) % 256;
        if (speed_req >= 2) start_sweep();
        else if (speed_req == 1) begin m_run = 0; m_pausing = 1; m_entry = m_cyc; end
        else if (man) start_sweep();
        else m_run = 0;
      end else if (m_cyc - m_entry >= TO) go_fault();
    end else if (m_pausing) begin
      if (speed_req >= 2) start_sweep();
      else if (speed_req == 0 && !man) m_pausing = 0;
      else if (m_cyc - m_entry >= SP) start_sweep();
    end else if (speed_req != 0 || man) begin
      start_sweep();
    end
  endtask

  always @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      m_fault = 0; m_run = 0; m_out = 0; m_pausing = 0; m_manual = 0; m_fast = 0;
      m_sweeps = 0; s1 = 0; s2 = 0;
    end else begin
      m_cyc++;
      m_ps = s2;
      s2 = s1;
      s1 = park_n;
      model_step(m_ps);
    end
  end

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge clk_2) begin
    chk("motor_on",   motor_on,   m_run);
    chk("motor_fast", motor_fast, m_fast);
    chk("sweep_cnt",  sweep_cnt,  m_sweeps);
    chk("busy",       busy,       (m_run || m_pausing || m_fault));
    chk("fault",      fault,      m_fault);
  end

  // Park sensor: 0 at park; rises 3 cycles into each sweep, falls 5 later.
  int   sens_mode = 0;
  int   t = 0;
  bit   prev_on = 0;
  logic [7:0] prev_cnt = 8'd0;
  always @(negedge clk_2) begin
    if (sens_mode == 1) park_n = 1'b0;
    else if (sens_mode == 2) park_n = 1'b1;
    else if (motor_on) begin
      if (!prev_on || sweep_cnt != prev_cnt) t = 0;
      else t++;
      park_n = (t >= 3 && t < 8);
    end
    prev_on  = motor_on;
    prev_cnt = sweep_cnt;
  end

  initial begin
    int n, lows, gaps, c0, lat, fast_low;
    bit fs;

    // Reset state with no clock edge yet.
    #2 reset = 1'b1;
    #1;
    chk("rst_motor_on", motor_on, 0);
    chk("rst_fast", motor_fast, 0);
    chk("rst_cnt", sweep_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    repeat (2) @(negedge clk_2);
    #2 reset = 1'b0;

    // Slow mode: 4-cycle gaps between sweeps, slow winding.
    @(negedge clk_2); speed_req = 2'd1;
    for (n = 0; n < 50; n++) begin @(negedge clk_2); if (motor_on) break; end
    chk("slow_start_wait", (n < 50), 1);
    lows = 0; gaps = 0; fs = 0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk_2);
      if (sweep_cnt == 8'd3) break;
      if (!motor_on) lows++;
      else begin
        if (lows > 0) begin chk("slow_gap", lows, 4); gaps++; lows = 0; end
        if (motor_fast) fs = 1;
      end
    end
    chk("slow_wait", (n < 200), 1);
    chk("slow_cnt", sweep_cnt, 3);
    chk("slow_gaps", gaps, 2);
    chk("slow_winding", fs, 0);

    // Reset in the middle of the return leg with five sweeps done.
    for (n = 0; n < 300; n++) begin
      @(negedge clk_2);
      if (m_sweeps == 5 && m_run && !m_out) break;
    end
    chk("ret5_wait", (n < 300), 1);
    chk("ret5_cnt", sweep_cnt, 5);
    #2 reset = 1'b1;
    #1;
    chk("midrst_motor_on", motor_on, 0);
    chk("midrst_cnt", sweep_cnt, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk_2); #2 reset = 1'b0;
    for (n = 0; n < 100; n++) begin @(negedge clk_2); if (sweep_cnt == 8'd1) break; end
    chk("after_rst_sweep", sweep_cnt, 1);

    // Fast mode: motor continuously on across sweeps.
    speed_req = 2'd0;
    for (n = 0; n < 100; n++) begin @(negedge clk_2); if (!busy) break; end
    chk("park_wait", busy, 0);
    speed_req = 2'd2;
    for (n = 0; n < 20; n++) begin @(negedge clk_2); if (motor_on) break; end
    c0 = sweep_cnt; lows = 0; fast_low = 0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk_2);
      if (sweep_cnt == 8'((c0 + 3) % 256)) break;
      if (!motor_on) lows++;
      if (!motor_fast) fast_low++;
    end
    chk("fast_wait", (n < 100), 1);
    chk("fast_lows", lows, 0);
    chk("fast_winding", fast_low, 0);
    for (n = 0; n < 30; n++) begin @(negedge clk_2); if (m_run && !m_out) break; end
    c0 = sweep_cnt;
    speed_req = 2'd0;
    for (n = 0; n < 60; n++) begin @(negedge clk_2); if (!busy) break; end
    chk("fast_stop_cnt", sweep_cnt, (c0 + 1) % 256);
    chk("fast_stop_busy", busy, 0);
    chk("fast_stop_motor", motor_on, 0);

    // Manual: one pulse, then two more during that sweep -> two sweeps total.
    c0 = sweep_cnt;
    @(negedge clk_2); wipe_once = 1'b1;
    @(negedge clk_2); wipe_once = 1'b0;
    repeat (2) @(negedge clk_2); wipe_once = 1'b1;
    @(negedge clk_2); wipe_once = 1'b0;
    repeat (2) @(negedge clk_2); wipe_once = 1'b1;
    @(negedge clk_2); wipe_once = 1'b0;
    for (n = 0; n < 100; n++) begin @(negedge clk_2); if (!busy) break; end
    chk("manual_sweeps", (sweep_cnt - c0) & 8'hFF, 2);
    chk("manual_parked", busy, 0);

    // Stuck sensor: fault exactly TO cycles after the sweep starts.
    sens_mode = 1;
    @(negedge clk_2); speed_req = 2'd1;
    for (n = 0; n < 20; n++) begin @(negedge clk_2); if (motor_on) break; end
    lat = -1;
    for (n = 0; n < 40; n++) begin @(negedge clk_2); if (fault) begin lat = n + 1; break; end end
    chk("fault_latency", lat, 16);
    chk("fault_motor_off", motor_on, 0);
    speed_req = 2'd0;
    @(negedge clk_2); fault_clr = 1'b1;
    @(negedge clk_2); fault_clr = 1'b0;
    chk("fault_cleared", fault, 0);
    chk("fault_clr_parked", busy, 0);
    sens_mode = 0;

    // Sweep counter wraps 255 -> 0.
    @(negedge clk_2); #2 reset = 1'b1;
    @(negedge clk_2); #2 reset = 1'b0;
    speed_req = 2'd2;
    for (n = 0; n < 4000; n++) begin @(negedge clk_2); if (sweep_cnt == 8'd255) break; end
    chk("wrap_255", sweep_cnt, 255);
    for (n = 0; n < 30; n++) begin @(negedge clk_2); if (sweep_cnt != 8'd255) break; end
    chk("wrap_0", sweep_cnt, 0);

    // Randomized traffic checked by the per-cycle compare.
    speed_req = 2'd0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_2);
      wipe_once = ($urandom_range(0, 19) == 0);
      fault_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) speed_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0)
        sens_mode = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    wipe_once = 1'b0;
    fault_clr = 1'b0;
    @(negedge clk_2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
